// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: serial line and ack in,
// received byte, status and error pulses out.
`timescale 1ns/1ps
interface uart_rx_if;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output rx, rx_ack,
    input  rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
  );

  modport slave (
    input  rx, rx_ack,
    output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampled mid-bit from the system clock, with a
// hold-until-acknowledged byte output plus framing and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 9600
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam logic [31:0] DIV_LAST  = 32'(DIV - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  bitn_q;
  logic [7:0]  sh_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        busy_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic        rx_s_d_q;

  // Synchronizer and edge history idle high so a line held low never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_s_d_q    <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      rx_s_d_q    <= rx_s_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (bus.rx_ack) valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (rx_s_d_q && !rx_s_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q  <= '0;
            bitn_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DATA: begin
          if (cnt_q == DIV_LAST) begin
            sh_q  <= {rx_s_q, sh_q[7:1]};
            cnt_q <= '0;
            if (bitn_q == 3'd7) state_q <= STOP;
            else                bitn_q  <= bitn_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so an immediately following start edge is seen.
          if (cnt_q == DIV_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
            end else if (!valid_q || bus.rx_ack) begin
              data_q  <= sh_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_busy      = busy_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_overrun   = overrun_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, LSB first, idle-high line, sampled from the single system clock at a fixed baud set by parameters. It is the receive-side counterpart of the design's UART transmitter and sits at the serial pin boundary. It delivers received bytes to the user logic through a hold-until-acknowledged valid/ack handshake. It also flags framing and overrun errors.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
BAUD, 9600, line bit rate
(derived) DIV = CLK_HZ/BAUD, using integer division; this is clocks per bit (2604 at the defaults)
(derived) HALF = DIV/2, using integer division (1302 at the defaults)

Ports:
clk  in  1  system clock; every register updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
rx  in  1  serial input; asynchronous to clk; idle level 1
rx_ack  in  1  user accepts the held byte; sampled on the clk edge
rx_data  out  8  last successfully received byte
rx_valid  out  1  high while rx_data holds an unacknowledged byte
rx_busy  out  1  high while the receiver is in any state other than IDLE
rx_frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0
rx_overrun  out  1  one-cycle pulse when a good byte completes while rx_valid is 1 and rx_ack is 0

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, rx_busy=0, rx_frame_err=0, rx_overrun=0, state=IDLE, counters=0. Both synchronizer flops and the edge-history flop reset to 1.
- Synchronizer: 2-flop synchronizer on rx, giving rx_s. rx_s_d is rx_s delayed by one cycle.
- Start detect happens only on a falling edge (rx_s_d=1 and rx_s=0) while in IDLE. A line that is held low, for example after reset or after a framing error, does not retrigger a start.
- State machine:
  - IDLE → START on start detect. Set cnt=0.
  - START: count to HALF-1, then sample rx_s.
    - If rx_s=1: false start. Return to IDLE with no flags.
    - If rx_s=0: go to DATA with cnt=0 and bitn=0.
  - DATA: at cnt=DIV-1, sample rx_s into the shift register as sh={rx_s, sh[7:1]} and reset cnt.
    - After bitn=7, go to STOP. Otherwise bitn increments.
  - STOP: at cnt=DIV-1, sample rx_s and go to IDLE in the same cycle. Returning to IDLE at mid-stop-bit is required so that back-to-back frames are caught.
    - Stop sample =1: good byte.
    - Stop sample =0: pulse rx_frame_err for one cycle. rx_data and rx_valid are unchanged and the byte is discarded.
- Good-byte delivery, evaluated in the STOP sample cycle:
  - If rx_valid=0 or rx_ack=1: rx_data←sh and rx_valid←1 on the next edge.
  - Otherwise: pulse rx_overrun for one cycle, discard the new byte, and keep the old rx_data and rx_valid.
- Acknowledge: rx_ack=1 while rx_valid=1 clears rx_valid on the next edge, unless a good byte is being delivered in that same cycle. In that case rx_data takes the new byte and rx_valid stays 1, with no overrun. rx_ack while rx_valid=0 is ignored.
- Counter widths: cnt is wide enough for DIV-1 (32 bits is acceptable). bitn is 3 bits.
- Latency: from the rx falling edge at the pin to rx_valid rising is 2 (synchronizer) + 1 (edge detect) + HALF + 9·DIV cycles, ±1. At the defaults this is ≈ 24741.
- Reset asserted mid-frame: all outputs and state return to reset values immediately (asynchronously). After release, the remainder of the frame is ignored until a new falling edge is seen.
- rx_busy equals (state ≠ IDLE), registered with the state.

Test Plan:
- Single byte 0xA5 at the default baud, rx_ack held 0 → rx_data=0xA5, rx_valid rises 24741±2 cycles after the start edge and stays high; raising rx_ack for one cycle → rx_valid=0 on the next edge.
- Glitch: rx low for 600 cycles (< HALF), then high → no rx_valid, no error pulses; rx_busy high for ≈1305 cycles, then 0.
- Framing error: byte 0x3C with the stop bit driven 0 → rx_frame_err is a single-cycle pulse; rx_valid stays 0 and rx_data stays 0x00. A subsequent good byte 0x11 (after the line has returned high) → rx_data=0x11.
- Back-to-back frames 0x00 then 0xFF, with no idle gap and rx_ack pulsed after each byte → both bytes delivered in order, no errors.
- Overrun: 0x12 then 0x34 without ack → rx_overrun pulses once, rx_data=0x12. Repeat with rx_ack asserted exactly in the 0x34 completion cycle → rx_data=0x34, rx_valid=1, no overrun.
- Reset pulse at mid-bit 4 of 0x5A → all outputs at reset values; no byte is delivered for the rest of that frame; the next frame, 0xC3, is received correctly.
